reg_scoreboard: RTL

Pending-write tracker that sits directly upstream of the 4-read/2-write general register file in the dual-issue pipeline. It records destination registers of issued, not-yet-written-back instructions and holds issue for any slot whose sources or destination conflict with in-flight writes. Its writeback inputs are the same two ports that drive the register file write side, so a register becomes readable exactly when the file holds the new value.

---
 rtl/reg_sb_pkg.sv | 19 +
 rtl/reg_sb_counter.sv | 49 ++++
 rtl/reg_scoreboard.sv | 86 ++++++++
 3 files changed

// File: rtl/reg_sb_pkg.sv
// Shared constants and types for the register scoreboard that tracks pending
// register writes in the dual-issue pipeline.
package reg_sb_pkg;
    localparam int REG_NUM       = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int SRC_PER_SLOT  = 2;
    localparam int ISSUE_WIDTH   = 2;
    localparam int DEF_CNT_WIDTH = 2;

    // Per-cycle change applied to one counter: 0, 1 or 2 events.
    typedef logic [1:0] cnt_delta_t;

    // Default-width pending-write counter.
    typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

    function automatic cnt_delta_t count_events(input logic a, input logic b);
        return cnt_delta_t'({1'b0, a}) + cnt_delta_t'({1'b0, b});
    endfunction
endpackage

// File: rtl/reg_sb_counter.sv
// One pending-write counter: adds issues and subtracts writebacks each cycle,
// clamps at the all-ones value and flags an underflow instead of wrapping.
module reg_sb_counter
    import reg_sb_pkg::*;
#(
    parameter int W = DEF_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  cnt_delta_t   i_inc,
    input  cnt_delta_t   i_dec,
    input  logic         i_clear,
    output logic [W-1:0] o_cnt,
    output logic         o_underflow
);
    localparam logic [W+1:0] MAX = (W+2)'((1 << W) - 1);

    logic [W-1:0] r_cnt;
    logic [W+1:0] w_sum;
    logic [W+1:0] w_dec;
    logic [W+1:0] w_diff;
    logic [W-1:0] w_next;
    logic         w_under;

    always_comb begin
        w_sum   = {2'b00, r_cnt} + {{W{1'b0}}, i_inc};
        w_dec   = {{W{1'b0}}, i_dec};
        w_diff  = w_sum - w_dec;
        w_under = !i_clear && (w_dec > w_sum);
        w_next  = w_diff[W-1:0];
        // A flush wipes everything and hides that cycle's issues and writebacks.
        if (i_clear || w_under) begin
            w_next = '0;
        end else if (w_diff > MAX) begin
            w_next = MAX[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_underflow = w_under;
endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard in front of the 4-read/2-write register file:
// holds issue on RAW hazards and on destination counters with no headroom.
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ISSUE_WIDTH-1:0]                iss_valid_i,
    input  logic [ISSUE_WIDTH-1:0][REG_ADDR_W-1:0] iss_dst_i,
    input  logic [ISSUE_WIDTH*SRC_PER_SLOT-1:0][REG_ADDR_W-1:0] iss_src_i,
    output logic [ISSUE_WIDTH-1:0]                iss_ready_o,
    output logic [ISSUE_WIDTH*SRC_PER_SLOT-1:0]   src_busy_o,
    input  logic [ISSUE_WIDTH-1:0][REG_ADDR_W-1:0] wb_addr_i,
    input  logic [ISSUE_WIDTH-1:0]                wb_en_i,
    input  logic                                  flush_i,
    output logic                                  err_o
);
    localparam logic [CNT_WIDTH+1:0] MAX = (CNT_WIDTH+2)'((1 << CNT_WIDTH) - 1);

    logic [CNT_WIDTH-1:0]   w_cnt [REG_NUM];
    logic [REG_NUM-1:0]     w_under;
    logic [ISSUE_WIDTH-1:0] w_ready;
    logic [ISSUE_WIDTH-1:0] w_fire;
    logic [ISSUE_WIDTH*SRC_PER_SLOT-1:0] w_busy;
    logic [CNT_WIDTH+1:0]   w_dst1_need;
    logic                   w_slot1_raw;
    logic                   r_err;

    assign w_cnt[0]   = '0;
    assign w_under[0] = 1'b0;

    always_comb begin
        for (int j = 0; j < ISSUE_WIDTH*SRC_PER_SLOT; j++) begin
            w_busy[j] = (iss_src_i[j] != '0) && (w_cnt[iss_src_i[j]] != '0);
        end
    end

    // Handshake: slot k issues on a cycle where iss_valid_i[k] && iss_ready_o[k].
    // Slot 0's ready ignores its own valid; slot 1's ready requires slot 0 to
    // issue in the same cycle, so issue stays strictly in order.
    always_comb begin
        w_slot1_raw = (iss_dst_i[0] != '0) &&
                      ((iss_src_i[2] == iss_dst_i[0]) || (iss_src_i[3] == iss_dst_i[0]));
        w_dst1_need = {2'b00, w_cnt[iss_dst_i[1]]} +
                      ((iss_dst_i[1] == iss_dst_i[0]) ? (CNT_WIDTH+2)'(2) : (CNT_WIDTH+2)'(1));
        w_ready[0]  = !flush_i && !w_busy[0] && !w_busy[1] &&
                      ((iss_dst_i[0] == '0) || ({2'b00, w_cnt[iss_dst_i[0]]} < MAX));
        w_ready[1]  = w_ready[0] && iss_valid_i[0] && !w_busy[2] && !w_busy[3] &&
                      !w_slot1_raw && ((iss_dst_i[1] == '0) || (w_dst1_need <= MAX));
        w_fire      = iss_valid_i & w_ready;
    end

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        cnt_delta_t w_inc;
        cnt_delta_t w_dec;

        assign w_inc = count_events(w_fire[0] && (iss_dst_i[0] == REG_ADDR_W'(r)),
                                    w_fire[1] && (iss_dst_i[1] == REG_ADDR_W'(r)));
        assign w_dec = count_events(wb_en_i[0] && (wb_addr_i[0] == REG_ADDR_W'(r)),
                                    wb_en_i[1] && (wb_addr_i[1] == REG_ADDR_W'(r)));

        reg_sb_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_inc      (w_inc),
            .i_dec      (w_dec),
            .i_clear    (flush_i),
            .o_cnt      (w_cnt[r]),
            .o_underflow(w_under[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_under);
        end
    end

    assign iss_ready_o = w_ready;
    assign src_busy_o  = w_busy;
    assign err_o       = r_err;
endmodule
